ct_split: RTL and testbench
===========================

// Module: ct_split
// PURPOSE
//  Packet-aware 1-to-NO router; the natural partner of the NI-to-1 merge.
//  Consumes one valid/ready/eop stream and samples a destination index on each packet's first beat.
//  Steers the whole packet to that output port, with no interleaving, until its eop beat is accepted.
//  Output side is fully registered via a 2-entry skid buffer: 1-cycle latency, full throughput, registered o_ready.
// PARAMETERS
//  NO     2   number of output ports (>=1)
//  WIDTH  32  data bits per beat
//  NOBITS     localparam, CLogB2(NO-1), minimum 1; width of i_dest
// PORTS
//  clk      in   1         clock, all state on rising edge
//  reset_n  in   1         asynchronous, active-low reset
//  i_data   in   WIDTH     input beat data
//  i_valid  in   1         input beat valid
//  o_ready  out  1         input ready (registered)
//  i_eop    in   1         last beat of packet
//  i_dest   in   NOBITS    destination port; sampled only on the first beat of a packet
//  o_data   out  WIDTH     output data, shared by all ports
//  o_eop    out  1         output eop, shared by all ports
//  o_valid  out  NO        one-hot-or-zero per-port valid
//  i_ready  in   NO        per-port ready
// BEHAVIOUR
//  Reset:
//   - o_valid=0, o_ready=0 while reset_n low; o_ready=1 on the first edge after release.
//   - o_data/o_eop=0; state=S_SOP; skid empty.
//  Handshake:
//   - Input beat accepted when i_valid&&o_ready.
//   - Output beat on port p accepted when o_valid[p]&&i_ready[p].
//   - o_valid[p] never drops until that beat is accepted; data/eop stay stable while stalled.
//  Latency and throughput:
//   - Beat accepted at cycle N is presented at cycle N+1 earliest.
//   - 1 beat/cycle sustained when the destination's ready is held high.
//  Skid buffer:
//   - Main register plus skid register; o_ready = !skid_valid.
//   - A beat accepted while the main register is stalled goes to skid; skid drains into main on the next output acceptance.
//   - Order is preserved.
//  FSM:
//   - S_SOP: an accepted beat latches dest_q=i_dest.
//       - eop=0 -> S_BODY.
//       - eop=1 (single-beat packet) -> stay in S_SOP.
//   - S_BODY: i_dest is ignored and beats use dest_q.
//       - Accepted beat with eop=1 -> S_SOP.
//  Each beat's destination travels with it through main/skid, so a new packet's sop can be accepted while the previous eop beat is still waiting at the output.
//  Boundaries:
//   - Both skid slots full: o_ready=0 until a beat drains.
//   - Simultaneous input accept and output accept with skid empty: main reloads directly, skid stays empty.
//   - Ready on a non-destination port has no effect.
//   - Output acceptance is evaluated on the registered destination only.
//   - reset_n asserted mid-packet: in-flight beats are discarded, FSM returns to S_SOP, and the next beat is treated as a sop.
// CONFIGURATION
//  Macro CT_SPLIT_DROP_EN, affecting sop beats with i_dest>=NO:
//   - Defined: the whole packet is accepted at full rate but never presented, and o_valid stays 0 for its beats.
//   - Defined: adds output port o_drop (1 bit), a sticky flag set on the sop of a dropped packet, cleared only by reset.
//   - Not defined: out-of-range destination is clamped to NO-1; there is no o_drop port.
//  Power-of-2 NO never produces out-of-range values in either mode.
// STRUCTURE
//  Package ct_pkg:
//   - CLogB2 function.
//   - typedef enum {S_SOP,S_BODY} ct_pkt_state_t, shared with the merge.
//   - typedef struct {data,eop,dest} beat type is module-local, parameterised.
//  Sub-module ct_split_skid (2-entry skid, WIDTH+1+NOBITS payload).
//   - ct_split holds the FSM, dest latch, drop logic and one-hot valid decode.
// TESTING
//  1. NO=4, WIDTH=8: single-beat packets with dest 0,1,2,3 back-to-back, all ready=1.
//     -> o_valid = 0001,0010,0100,1000 on consecutive cycles; o_ready stays 1.
//  2. 3-beat packet to dest=2 with data A1,A2,A3; i_dest changes to 0 on beats 2-3.
//     -> all three beats appear on port 2 only.
//  3. Packet to dest=1; i_ready[1]=0 for 3 cycles after the first beat.
//     -> o_ready falls after 2 beats are held; data is unchanged on release; no beat is lost or duplicated.
//  4. 2-beat packet to dest 3, eop stalled by i_ready[3]=0 while the next sop to dest 0 arrives.
//     -> sop beat is buffered; ports 0 and 3 never both valid; order is preserved.
//  5. Assert reset_n=0 during beat 2 of a 4-beat packet, then send a new 1-beat packet to dest 1.
//     -> all o_valid=0 during reset; new packet routed to port 1.
//  6. NO=3, sop with dest=3.
//     -> DROP_EN: no o_valid, o_drop=1, next packet is routed normally.
//     -> default: packet on port 2.

Source files
------------

// File: rtl/ct_pkg.sv
// Shared definitions for the ct_* packet stream blocks (split and merge).
package ct_pkg;

    typedef enum logic [0:0] {
        S_SOP  = 1'b0,
        S_BODY = 1'b1
    } ct_pkt_state_t;

    // Bits needed to hold value, never less than one.
    function automatic int CLogB2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((value >> i) != 0) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ct_split_if.sv
// Stream bundle for ct_split: one valid/ready/eop input, NO-way shared-data output.
interface ct_split_if #(
    parameter int NO    = 2,
    parameter int WIDTH = 32
);
    import ct_pkg::*;

    localparam int NOBITS = CLogB2(NO - 1);

    logic [WIDTH-1:0]  i_data;
    logic              i_valid;
    logic              o_ready;
    logic              i_eop;
    logic [NOBITS-1:0] i_dest;
    logic [WIDTH-1:0]  o_data;
    logic              o_eop;
    logic [NO-1:0]     o_valid;
    logic [NO-1:0]     i_ready;

    modport slave (
        input  i_data, i_valid, i_eop, i_dest, i_ready,
        output o_ready, o_data, o_eop, o_valid
    );

    modport master (
        output i_data, i_valid, i_eop, i_dest, i_ready,
        input  o_ready, o_data, o_eop, o_valid
    );

endinterface

// File: rtl/ct_split_skid.sv
// Two-entry skid buffer: registered output and registered ready, one beat per cycle.
module ct_split_skid #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [PW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [PW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    logic [PW-1:0] main_q, main_d, skid_q, skid_d;
    logic          main_v, main_v_d, skid_v, skid_v_d;
    logic          rdy_q;
    logic          in_acc;

    assign in_acc = in_valid && rdy_q;

    // Skid only fills while main is stalled, so an occupied skid implies rdy_q=0.
    always_comb begin
        main_d   = main_q;
        main_v_d = main_v;
        skid_d   = skid_q;
        skid_v_d = skid_v;
        if (!main_v || out_ready) begin
            if (skid_v) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else if (in_acc) begin
                main_d   = in_data;
                main_v_d = 1'b1;
            end else begin
                main_v_d = 1'b0;
            end
        end else if (in_acc) begin
            skid_d   = in_data;
            skid_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_q <= '0;
            main_v <= 1'b0;
            skid_q <= '0;
            skid_v <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            main_q <= main_d;
            main_v <= main_v_d;
            skid_q <= skid_d;
            skid_v <= skid_v_d;
            rdy_q  <= !skid_v_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_data  = main_q;
    assign out_valid = main_v;

endmodule

// File: rtl/ct_split.sv
// Packet-aware 1-to-NO router. Define CT_SPLIT_DROP_EN to drop packets whose
// sop destination is out of range (adds sticky o_drop); otherwise it is clamped to NO-1.
//
// state  | meaning
// S_SOP  | next accepted beat is a packet's first; i_dest is sampled
// S_BODY | mid-packet; beats reuse dest_q until the eop beat is accepted
module ct_split
    import ct_pkg::*;
#(
    parameter int NO    = 2,
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    ct_split_if.slave  bus
`ifdef CT_SPLIT_DROP_EN
    ,
    output logic       o_drop
`endif
);

    localparam int NOBITS = CLogB2(NO - 1);
    localparam logic [NOBITS:0]   NO_EXT    = (NOBITS + 1)'(NO);
    localparam logic [NOBITS-1:0] LAST_PORT = NOBITS'(NO - 1);

    typedef struct packed {
        logic [WIDTH-1:0]  data;
        logic              eop;
        logic [NOBITS-1:0] dest;
    } beat_t;

    ct_pkt_state_t     state_q, state_d;
    logic [NOBITS-1:0] dest_q, dest_d, sop_dest, beat_dest;
    logic              drop_q, drop_d, sop_drop, beat_drop;
    logic              dest_oob, in_acc, push;
    beat_t             in_beat, out_beat;
    logic              out_valid, out_ready, skid_ready;
    logic [NO-1:0]     valid_dec;

    assign dest_oob = {1'b0, bus.i_dest} >= NO_EXT;

`ifdef CT_SPLIT_DROP_EN
    assign sop_dest = bus.i_dest;
    assign sop_drop = dest_oob;
`else
    assign sop_dest = dest_oob ? LAST_PORT : bus.i_dest;
    assign sop_drop = 1'b0;
`endif

    assign in_acc = bus.i_valid && skid_ready;

    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        drop_d    = drop_q;
        beat_dest = dest_q;
        beat_drop = drop_q;
        case (state_q)
            S_SOP: begin
                beat_dest = sop_dest;
                beat_drop = sop_drop;
                if (in_acc) begin
                    dest_d = sop_dest;
                    drop_d = sop_drop;
                    if (!bus.i_eop) state_d = S_BODY;
                end
            end
            S_BODY: begin
                if (in_acc && bus.i_eop) state_d = S_SOP;
            end
            default: state_d = S_SOP;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_SOP;
            dest_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            drop_q  <= drop_d;
        end
    end

`ifdef CT_SPLIT_DROP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_drop <= 1'b0;
        end else if (in_acc && state_q == S_SOP && sop_drop) begin
            o_drop <= 1'b1;
        end
    end
`endif

    // Dropped beats are still consumed at full rate, they just never enter the buffer.
    assign push    = in_acc && !beat_drop;
    assign in_beat = '{data: bus.i_data, eop: bus.i_eop, dest: beat_dest};

    ct_split_skid #(
        .PW($bits(beat_t))
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_beat),
        .in_valid  (push),
        .in_ready  (skid_ready),
        .out_data  (out_beat),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always_comb begin
        valid_dec = '0;
        for (int p = 0; p < NO; p++) begin
            if (out_valid && out_beat.dest == NOBITS'(p)) valid_dec[p] = 1'b1;
        end
    end

    assign out_ready   = |(valid_dec & bus.i_ready);
    assign bus.o_valid = valid_dec;
    assign bus.o_data  = out_beat.data;
    assign bus.o_eop   = out_beat.eop;
    assign bus.o_ready = skid_ready;

endmodule

// File: tb/tb_ct_split.sv
// Directed bench for ct_split: a NO=4 instance for routing/stall/reset, a NO=3 instance for out-of-range dest.
module tb_ct_split;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    ct_split_if #(.NO(4), .WIDTH(8)) b4 ();
    ct_split_if #(.NO(3), .WIDTH(8)) b3 ();

`ifdef CT_SPLIT_DROP_EN
    logic drop4, drop3;
`endif

    ct_split #(.NO(4), .WIDTH(8)) u4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b4)
`ifdef CT_SPLIT_DROP_EN
        ,
        .o_drop  (drop4)
`endif
    );

    ct_split #(.NO(3), .WIDTH(8)) u3 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b3)
`ifdef CT_SPLIT_DROP_EN
        ,
        .o_drop  (drop3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv4(input logic v, input logic [7:0] d, input logic [1:0] dst, input logic e);
        b4.i_valid = v;
        b4.i_data  = d;
        b4.i_dest  = dst;
        b4.i_eop   = e;
    endtask

    task automatic drv3(input logic v, input logic [7:0] d, input logic [1:0] dst, input logic e);
        b3.i_valid = v;
        b3.i_data  = d;
        b3.i_dest  = dst;
        b3.i_eop   = e;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        drv4(1'b0, 8'h00, 2'd0, 1'b0);
        drv3(1'b0, 8'h00, 2'd0, 1'b0);
        b4.i_ready = 4'b1111;
        b3.i_ready = 3'b111;

        // reset state
        tick();
        tick();
        chk("rst_valid", b4.o_valid, 4'b0000);
        chk("rst_ready", b4.o_ready, 1'b0);
        chk("rst_data", b4.o_data, 8'h00);
        chk("rst_eop", b4.o_eop, 1'b0);
`ifdef CT_SPLIT_DROP_EN
        chk("rst_drop", drop3, 1'b0);
`endif
        reset_n = 1'b1;
        tick();
        chk("rel_ready", b4.o_ready, 1'b1);
        chk("rel_valid", b4.o_valid, 4'b0000);

        // 1: single-beat packets to each port back to back
        drv4(1'b1, 8'h10, 2'd0, 1'b1);
        tick();
        chk("t1_v0", b4.o_valid, 4'b0001);
        chk("t1_d0", b4.o_data, 8'h10);
        chk("t1_r0", b4.o_ready, 1'b1);
        drv4(1'b1, 8'h11, 2'd1, 1'b1);
        tick();
        chk("t1_v1", b4.o_valid, 4'b0010);
        chk("t1_d1", b4.o_data, 8'h11);
        chk("t1_r1", b4.o_ready, 1'b1);
        drv4(1'b1, 8'h12, 2'd2, 1'b1);
        tick();
        chk("t1_v2", b4.o_valid, 4'b0100);
        chk("t1_d2", b4.o_data, 8'h12);
        drv4(1'b1, 8'h13, 2'd3, 1'b1);
        tick();
        chk("t1_v3", b4.o_valid, 4'b1000);
        chk("t1_d3", b4.o_data, 8'h13);
        chk("t1_e3", b4.o_eop, 1'b1);
        drv4(1'b0, 8'h00, 2'd0, 1'b0);
        tick();
        chk("t1_idle", b4.o_valid, 4'b0000);

        // 2: 3-beat packet to port 2, i_dest wanders to 0 mid-packet
        drv4(1'b1, 8'hA1, 2'd2, 1'b0);
        tick();
        chk("t2_v1", b4.o_valid, 4'b0100);
        chk("t2_d1", b4.o_data, 8'hA1);
        chk("t2_e1", b4.o_eop, 1'b0);
        drv4(1'b1, 8'hA2, 2'd0, 1'b0);
        tick();
        chk("t2_v2", b4.o_valid, 4'b0100);
        chk("t2_d2", b4.o_data, 8'hA2);
        drv4(1'b1, 8'hA3, 2'd0, 1'b1);
        tick();
        chk("t2_v3", b4.o_valid, 4'b0100);
        chk("t2_d3", b4.o_data, 8'hA3);
        chk("t2_e3", b4.o_eop, 1'b1);
        drv4(1'b0, 8'h00, 2'd0, 1'b0);
        tick();
        chk("t2_idle", b4.o_valid, 4'b0000);

        // 3: port 1 stalls three cycles; other ports stay ready
        drv4(1'b1, 8'hB1, 2'd1, 1'b0);
        tick();
        chk("t3_v1", b4.o_valid, 4'b0010);
        chk("t3_d1", b4.o_data, 8'hB1);
        b4.i_ready = 4'b1101;
        drv4(1'b1, 8'hB2, 2'd1, 1'b0);
        tick();
        chk("t3_hold_d", b4.o_data, 8'hB1);
        chk("t3_hold_v", b4.o_valid, 4'b0010);
        chk("t3_full_r", b4.o_ready, 1'b0);
        drv4(1'b1, 8'hB3, 2'd1, 1'b0);
        tick();
        chk("t3_hold2_d", b4.o_data, 8'hB1);
        chk("t3_full2_r", b4.o_ready, 1'b0);
        tick();
        chk("t3_hold3_d", b4.o_data, 8'hB1);
        chk("t3_hold3_v", b4.o_valid, 4'b0010);
        b4.i_ready = 4'b1111;
        tick();
        chk("t3_rel_d", b4.o_data, 8'hB2);
        chk("t3_rel_v", b4.o_valid, 4'b0010);
        chk("t3_rel_r", b4.o_ready, 1'b1);
        tick();
        chk("t3_b3_d", b4.o_data, 8'hB3);
        drv4(1'b1, 8'hB4, 2'd1, 1'b1);
        tick();
        chk("t3_b4_d", b4.o_data, 8'hB4);
        chk("t3_b4_e", b4.o_eop, 1'b1);
        drv4(1'b0, 8'h00, 2'd0, 1'b0);
        tick();
        chk("t3_idle", b4.o_valid, 4'b0000);

        // 4: eop to port 3 stalled while next sop (port 0) is buffered behind it
        drv4(1'b1, 8'hC1, 2'd3, 1'b0);
        tick();
        chk("t4_c1_v", b4.o_valid, 4'b1000);
        drv4(1'b1, 8'hC2, 2'd1, 1'b1);
        tick();
        chk("t4_c2_v", b4.o_valid, 4'b1000);
        chk("t4_c2_d", b4.o_data, 8'hC2);
        b4.i_ready = 4'b0111;
        drv4(1'b1, 8'hD1, 2'd0, 1'b1);
        tick();
        chk("t4_stall_v", b4.o_valid, 4'b1000);
        chk("t4_stall_d", b4.o_data, 8'hC2);
        chk("t4_stall_r", b4.o_ready, 1'b0);
        drv4(1'b0, 8'h00, 2'd0, 1'b0);
        tick();
        chk("t4_stall2_v", b4.o_valid, 4'b1000);
        b4.i_ready = 4'b1111;
        tick();
        chk("t4_d1_v", b4.o_valid, 4'b0001);
        chk("t4_d1_d", b4.o_data, 8'hD1);
        chk("t4_d1_r", b4.o_ready, 1'b1);
        tick();
        chk("t4_idle", b4.o_valid, 4'b0000);

        // 5: reset in the middle of a packet to port 2
        drv4(1'b1, 8'hE1, 2'd2, 1'b0);
        tick();
        chk("t5_e1_v", b4.o_valid, 4'b0100);
        drv4(1'b1, 8'hE2, 2'd2, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_v", b4.o_valid, 4'b0000);
        chk("t5_rst_r", b4.o_ready, 1'b0);
        tick();
        chk("t5_rst2_v", b4.o_valid, 4'b0000);
        drv4(1'b0, 8'h00, 2'd0, 1'b0);
        reset_n = 1'b1;
        tick();
        chk("t5_rel_r", b4.o_ready, 1'b1);
        drv4(1'b1, 8'hF1, 2'd1, 1'b1);
        tick();
        chk("t5_f1_v", b4.o_valid, 4'b0010);
        chk("t5_f1_d", b4.o_data, 8'hF1);
        drv4(1'b0, 8'h00, 2'd0, 1'b0);
        tick();
        chk("t5_idle", b4.o_valid, 4'b0000);

        // 6: NO=3, two-beat packet whose sop names port 3
        chk("t6_r0", b3.o_ready, 1'b1);
        drv3(1'b1, 8'h66, 2'd3, 1'b0);
        tick();
`ifdef CT_SPLIT_DROP_EN
        chk("t6_g1_v", b3.o_valid, 3'b000);
        chk("t6_drop", drop3, 1'b1);
`else
        chk("t6_g1_v", b3.o_valid, 3'b100);
        chk("t6_g1_d", b3.o_data, 8'h66);
`endif
        chk("t6_r1", b3.o_ready, 1'b1);
        drv3(1'b1, 8'h67, 2'd0, 1'b1);
        tick();
`ifdef CT_SPLIT_DROP_EN
        chk("t6_g2_v", b3.o_valid, 3'b000);
`else
        chk("t6_g2_v", b3.o_valid, 3'b100);
        chk("t6_g2_d", b3.o_data, 8'h67);
`endif
        drv3(1'b1, 8'h77, 2'd1, 1'b1);
        tick();
        chk("t6_h_v", b3.o_valid, 3'b010);
        chk("t6_h_d", b3.o_data, 8'h77);
        drv3(1'b0, 8'h00, 2'd0, 1'b0);
        tick();
        chk("t6_idle", b3.o_valid, 3'b000);
`ifdef CT_SPLIT_DROP_EN
        chk("t6_drop_sticky", drop3, 1'b1);
        chk("t6_drop4", drop4, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
